// File: rtl/vga_scan_driver.sv
// VGA raster timing master and pixel output stage with delay-matched syncs.
// Optional build macro VGA_TEST_PATTERN_EN adds a colour-bar test_pattern input.

module vga_scan_driver #(
  parameter int CLK_DIV     = 2,
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int PPU_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  output logic [9:0]  hcount,
  output logic [9:0]  vcount,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic        vga_hs,
  output logic        vga_vs,
  output logic        vga_blank_n,
  output logic        vga_sync_n,
  output logic        vga_clk,
  output logic        vblank,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = $clog2(CLK_DIV);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
  localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic             pix_en;
  logic [9:0]       hcount_q, hcount_d;
  logic [9:0]       vcount_q, vcount_d;
  logic             vga_clk_q, vblank_q, frame_start_q, frame_start_d;
  logic             hs_raw, vs_raw, act_raw;
  logic             hs_del, vs_del, act_del;
  logic [23:0]      pix_src, rgb_d, rgb_q;
  logic             hs_q, vs_q, blank_q;
`ifdef VGA_TEST_PATTERN_EN
  logic [9:0]       hc_del;
  logic [9:0]       bar_num;
  logic [23:0]      bar_rgb;
`endif

  always_comb begin
    pix_en   = (div_q == DIV_LAST);
    div_d    = pix_en ? '0 : div_q + 1'b1;
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en) begin
      if (hcount_q == H_LAST) begin
        hcount_d = '0;
        vcount_d = (vcount_q == V_LAST) ? '0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
    frame_start_d = pix_en && (hcount_q == H_LAST) && (vcount_q == V_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q         <= '0;
      hcount_q      <= '0;
      vcount_q      <= '0;
      vga_clk_q     <= 1'b0;
      vblank_q      <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      vga_clk_q     <= (div_d >= DIV_HALF);
      vblank_q      <= (vcount_d >= V_VIS);
      frame_start_q <= frame_start_d;
    end
  end

  always_comb begin
    hs_raw  = !((hcount_q >= HS_START) && (hcount_q <= HS_END));
    vs_raw  = !((vcount_q >= VS_START) && (vcount_q <= VS_END));
    act_raw = (hcount_q < H_VIS) && (vcount_q < V_VIS);
  end

  // Raster attributes wait PPU_LATENCY pixels so they meet the PPU's colour.
  generate
    if (PPU_LATENCY == 0) begin : g_nodelay
      assign hs_del  = hs_raw;
      assign vs_del  = vs_raw;
      assign act_del = act_raw;
`ifdef VGA_TEST_PATTERN_EN
      assign hc_del  = hcount_q;
`endif
    end else begin : g_delay
      logic [PPU_LATENCY-1:0] hs_dl_q, vs_dl_q, act_dl_q;
`ifdef VGA_TEST_PATTERN_EN
      logic [9:0] hc_dl_q [PPU_LATENCY];
`endif
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          hs_dl_q  <= '1;
          vs_dl_q  <= '1;
          act_dl_q <= '0;
`ifdef VGA_TEST_PATTERN_EN
          for (int i = 0; i < PPU_LATENCY; i++) hc_dl_q[i] <= '0;
`endif
        end else if (pix_en) begin
          hs_dl_q[0]  <= hs_raw;
          vs_dl_q[0]  <= vs_raw;
          act_dl_q[0] <= act_raw;
`ifdef VGA_TEST_PATTERN_EN
          hc_dl_q[0]  <= hcount_q;
`endif
          for (int i = 1; i < PPU_LATENCY; i++) begin
            hs_dl_q[i]  <= hs_dl_q[i-1];
            vs_dl_q[i]  <= vs_dl_q[i-1];
            act_dl_q[i] <= act_dl_q[i-1];
`ifdef VGA_TEST_PATTERN_EN
            hc_dl_q[i]  <= hc_dl_q[i-1];
`endif
          end
        end
      end
      assign hs_del  = hs_dl_q[PPU_LATENCY-1];
      assign vs_del  = vs_dl_q[PPU_LATENCY-1];
      assign act_del = act_dl_q[PPU_LATENCY-1];
`ifdef VGA_TEST_PATTERN_EN
      assign hc_del  = hc_dl_q[PPU_LATENCY-1];
`endif
    end
  endgenerate

`ifdef VGA_TEST_PATTERN_EN
  always_comb begin
    bar_num = hc_del / 10'(H_ACTIVE / 8);
    case (bar_num)
      10'd0:   bar_rgb = 24'hFFFFFF;
      10'd1:   bar_rgb = 24'hFFFF00;
      10'd2:   bar_rgb = 24'h00FFFF;
      10'd3:   bar_rgb = 24'h00FF00;
      10'd4:   bar_rgb = 24'hFF00FF;
      10'd5:   bar_rgb = 24'hFF0000;
      10'd6:   bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
    pix_src = test_pattern ? bar_rgb : rgb_in;
  end
`else
  assign pix_src = rgb_in;
`endif

  assign rgb_d = act_del ? pix_src : 24'h000000;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rgb_q   <= '0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      blank_q <= 1'b0;
    end else if (pix_en) begin
      rgb_q   <= rgb_d;
      hs_q    <= hs_del;
      vs_q    <= vs_del;
      blank_q <= act_del;
    end
  end

  assign hcount      = hcount_q;
  assign vcount      = vcount_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_blank_n = blank_q;
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vga_clk_q;
  assign vblank      = vblank_q;
  assign frame_start = frame_start_q;

endmodule
